// File: rtl/fft_pkg.sv
// Shared FFT constants, bit-reversal helper and frame-buffer status codes.
package fft_pkg;

  localparam int FFT_LOG2N = 6;
  localparam int FFT_N     = 1 << FFT_LOG2N;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_READING
  } buf_st_e;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } w_st_e;

  typedef enum logic {
    R_IDLE,
    R_STREAM
  } r_st_e;

  // Reverses the low w bits of x; bits above w come back zero.
  function automatic logic [15:0] bitrev(
    input logic [15:0] x,
    input int          w
  );
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) r = {r[14:0], x[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/simple_dualport_RAM.sv
// One write port, one registered read port; read data holds while re_i is low.
module simple_dualport_RAM #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed DIF result pairs in,
// natural-order complex samples out under valid/ready.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int BW    = 16,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic [BW-1:0]    inReal0,
  input  logic [BW-1:0]    inImag0,
  input  logic [BW-1:0]    inReal1,
  input  logic [BW-1:0]    inImag1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    outReal,
  output logic [BW-1:0]    outImag,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             overflow,
  output logic             sync_err
);

  localparam int HA = LOG2N - 1;
  localparam int DW = 2 * BW;

  buf_st_e stat_q [2];
  buf_st_e stat_d [2];

  w_st_e            w_state_q, w_state_d;
  logic             w_buf_q, w_buf_d;
  logic [HA-1:0]    w_cnt_q, w_cnt_d;
  logic             ovf_q, ovf_d;
  logic             serr_q, serr_d;
  logic             we, wr_buf, w_claim, w_done;
  logic [HA-1:0]    wr_k;
  logic [LOG2N-1:0] waddr;

  r_st_e            r_state_q, r_state_d;
  logic             rbuf_q, rbuf_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic             r_claim, issue, adv;
  logic             full_any, pick, rel;
  logic             old_q, old_d;

  logic             ov_q, last_q, half_q, obuf_q;
  logic [LOG2N-1:0] idx_q;
  logic [DW-1:0]    rd_l, rd_h, rd_sel;

  always_comb begin
    w_state_d = w_state_q;
    w_buf_d   = w_buf_q;
    w_cnt_d   = w_cnt_q;
    ovf_d     = ovf_q;
    serr_d    = serr_q;
    we        = 1'b0;
    wr_buf    = w_buf_q;
    wr_k      = '0;
    w_claim   = 1'b0;
    w_done    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (in_valid && in_first) begin
          if (stat_q[0] == B_EMPTY ||
              stat_q[1] == B_EMPTY) begin
            w_buf_d   = stat_q[0] != B_EMPTY;
            wr_buf    = w_buf_d;
            we        = 1'b1;
            w_claim   = 1'b1;
            w_cnt_d   = HA'(1);
            w_state_d = W_FILL;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          we = 1'b1;
          if (in_first) begin
            // Restart in place; later pairs overwrite the stale ones.
            serr_d  = 1'b1;
            w_cnt_d = HA'(1);
          end else begin
            wr_k = w_cnt_q;
            if (&w_cnt_q) begin
              w_done    = 1'b1;
              w_cnt_d   = '0;
              w_state_d = W_IDLE;
            end else begin
              w_cnt_d = w_cnt_q + HA'(1);
            end
          end
        end
      end
      default: ;
    endcase
    waddr = {wr_buf,
             HA'(bitrev(16'({wr_k, 1'b0}), LOG2N))};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_buf_q   <= 1'b0;
      w_cnt_q   <= '0;
      ovf_q     <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_buf_q   <= w_buf_d;
      w_cnt_q   <= w_cnt_d;
      ovf_q     <= ovf_d;
      serr_q    <= serr_d;
    end
  end

  // old_q tracks which FULL buffer completed first.
  assign full_any = stat_q[0] == B_FULL || stat_q[1] == B_FULL;
  assign pick     = stat_q[old_q] == B_FULL ? old_q : ~old_q;
  assign adv      = !ov_q || out_ready;
  assign rel      = ov_q && out_ready && last_q;

  always_comb begin
    r_state_d = r_state_q;
    rbuf_d    = rbuf_q;
    n_d       = n_q;
    r_claim   = 1'b0;
    issue     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (full_any) begin
          r_claim   = 1'b1;
          rbuf_d    = pick;
          n_d       = '0;
          r_state_d = R_STREAM;
        end
      end
      R_STREAM: begin
        if (adv) begin
          issue = 1'b1;
          if (&n_q) begin
            n_d = '0;
            if (full_any) begin
              r_claim = 1'b1;
              rbuf_d  = pick;
            end else begin
              r_state_d = R_IDLE;
            end
          end else begin
            n_d = n_q + LOG2N'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stat_d = stat_q;
    old_d  = old_q;
    if (w_claim) stat_d[w_buf_d] = B_FILLING;
    if (w_done) begin
      stat_d[w_buf_q] = B_FULL;
      if (stat_q[~w_buf_q] != B_FULL) old_d = w_buf_q;
    end
    if (r_claim) stat_d[rbuf_d] = B_READING;
    if (rel) stat_d[obuf_q] = B_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q[0] <= B_EMPTY;
      stat_q[1] <= B_EMPTY;
      old_q     <= 1'b0;
      r_state_q <= R_IDLE;
      rbuf_q    <= 1'b0;
      n_q       <= '0;
    end else begin
      stat_q    <= stat_d;
      old_q     <= old_d;
      r_state_q <= r_state_d;
      rbuf_q    <= rbuf_d;
      n_q       <= n_d;
    end
  end

  // Output stage; the RAM output register doubles as the data holder.
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q   <= 1'b0;
      last_q <= 1'b0;
      half_q <= 1'b0;
      obuf_q <= 1'b0;
      idx_q  <= '0;
    end else if (adv) begin
      ov_q   <= issue;
      last_q <= issue && (&n_q);
      if (issue) begin
        idx_q  <= n_q;
        half_q <= n_q[HA];
        obuf_q <= rbuf_q;
      end
    end
  end

  simple_dualport_RAM #(
    .DW(DW),
    .AW(LOG2N)
  ) u_ram_l (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i({inReal0, inImag0}),
    .re_i   (issue),
    .raddr_i({rbuf_q, n_q[HA-1:0]}),
    .rdata_o(rd_l)
  );

  simple_dualport_RAM #(
    .DW(DW),
    .AW(LOG2N)
  ) u_ram_h (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i({inReal1, inImag1}),
    .re_i   (issue),
    .raddr_i({rbuf_q, n_q[HA-1:0]}),
    .rdata_o(rd_h)
  );

  assign rd_sel    = half_q ? rd_h : rd_l;
  assign out_valid = ov_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign outReal   = ov_q ? rd_sel[DW-1:BW] : '0;
  assign outImag   = ov_q ? rd_sel[BW-1:0] : '0;
  assign overflow  = ovf_q;
  assign sync_err  = serr_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: directed frames, queue of
// expected natural-order samples, negedge monitor.
module tb_fft_out_reorder;

  typedef struct packed {
    logic [5:0]  idx;
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic [15:0] inReal0 = '0;
  logic [15:0] inImag0 = '0;
  logic [15:0] inReal1 = '0;
  logic [15:0] inImag1 = '0;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] outReal;
  logic [15:0] outImag;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        overflow;
  logic        sync_err;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rdy_mode = 1;
  int   first_valid_cyc = -1;
  int   last_pair_cyc = 0;
  int   gaps = 0;

  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic [5:0]  s_idx;
  logic [15:0] s_re, s_im;
  logic        s_last;

  fft_out_reorder #(
    .BW   (16),
    .LOG2N(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_first (in_first),
    .inReal0  (inReal0),
    .inImag0  (inImag0),
    .inReal1  (inReal1),
    .inImag1  (inImag1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .outReal  (outReal),
    .outImag  (outImag),
    .out_idx  (out_idx),
    .out_last (out_last),
    .overflow (overflow),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (!out_valid || out_idx != s_idx || outReal != s_re ||
            outImag != s_im || out_last != s_last) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b idx=%0d re=%h im=%h, held idx=%0d re=%h im=%h",
                   out_valid, out_idx, outReal, outImag, s_idx, s_re, s_im);
        end
      end
      if (out_valid && !prev_valid && first_valid_cyc < 0)
        first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: got idx=%0d re=%h, expected none",
                   out_idx, outReal);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_idx != e.idx || outReal != e.re ||
              outImag != e.im || out_last != e.last) begin
            n_bad++;
            $display("FAIL sample: got idx=%0d re=%h im=%h last=%0b, expected idx=%0d re=%h im=%h last=%0b",
                     out_idx, outReal, outImag, out_last,
                     e.idx, e.re, e.im, e.last);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      s_idx  = out_idx;
      s_re   = outReal;
      s_im   = outImag;
      s_last = out_last;
    end
  end

  function automatic int rev6(input int x);
    int r;
    r = 0;
    for (int i = 5; i >= 0; i--) r = r | (((x >> (5 - i)) & 1) << i);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_frame(input int base);
    for (int n = 0; n < 64; n++) begin
      exp_t e;
      e.idx  = 6'(n);
      e.re   = 16'(base + n);
      e.im   = 16'(-(base + n));
      e.last = (n == 63);
      sb.push_back(e);
    end
  endtask

  task automatic send_pairs(input int base, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      int i0;
      @(posedge clk);
      #1;
      i0 = rev6(2 * k);
      in_valid = 1'b1;
      in_first = (k == 0);
      inReal0  = 16'(base + i0);
      inImag0  = 16'(-(base + i0));
      inReal1  = 16'(base + i0 + 32);
      inImag1  = 16'(-(base + i0 + 32));
      last_pair_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
    end
  endtask

  task automatic drain(input string nm, input int bound);
    int t;
    t = 0;
    while (sb.size() != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d samples outstanding, expected 0",
               nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_real", int'(outReal), 0);
    chk("rst_imag", int'(outImag), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_serr", int'(sync_err), 0);

    first_valid_cyc = -1;
    push_frame(0);
    send_pairs(0, 0, 31);
    idle(1);
    drain("single_frame", 200);
    chk("latency", first_valid_cyc - last_pair_cyc, 3);

    push_frame(16'h100);
    push_frame(16'h200);
    fork
      begin
        send_pairs(16'h100, 0, 31);
        send_pairs(16'h200, 0, 31);
        idle(1);
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid && t < 300);
        for (int i = 0; i < 128; i++) begin
          if (!out_valid) gaps++;
          if (i < 127) @(negedge clk);
        end
      end
    join
    drain("back_to_back", 300);
    chk("b2b_bubbles", gaps, 0);
    chk("b2b_ovf", int'(overflow), 0);

    rdy_mode = 2;
    push_frame(16'h300);
    send_pairs(16'h300, 0, 31);
    idle(1);
    drain("random_ready", 600);
    rdy_mode = 1;
    chk("rand_serr", int'(sync_err), 0);

    rdy_mode = 0;
    idle(2);
    push_frame(16'h400);
    push_frame(16'h500);
    send_pairs(16'h400, 0, 31);
    send_pairs(16'h500, 0, 31);
    send_pairs(16'h600, 0, 31);
    idle(4);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_pending", sb.size(), 128);
    rdy_mode = 1;
    drain("ovf_release", 400);
    idle(5);

    push_frame(16'h800);
    send_pairs(16'h700, 0, 9);
    send_pairs(16'h800, 0, 31);
    idle(1);
    drain("sync_restart", 300);
    chk("serr_set", int'(sync_err), 1);
    chk("ovf_sticky", int'(overflow), 1);

    push_frame(16'h900);
    send_pairs(16'h900, 0, 31);
    idle(1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(out_valid && out_idx == 6'd20) && t < 200);
    chk("reach_idx20", int'(out_idx), 20);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_serr", int'(sync_err), 0);
    chk("mid_rst_last", int'(out_last), 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    push_frame(16'hA00);
    send_pairs(16'hA00, 0, 31);
    idle(1);
    drain("post_rst", 200);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer on the far side of the in-place radix-2 DIF FFT. Accepts the core's two-sample-per-cycle, bit-reversed result pairs (outReal0/outImag0, outReal1/outImag1) and streams them one complex sample per cycle in natural index order, with a valid/ready handshake toward the downstream consumer. Double-buffered (ping-pong) so one frame can be written while the previous one is read.

## Interface
- BW, 16: bit width of each real/imag component
- LOG2N, 6: log2 of FFT length N (N = 64); pairs per frame = N/2
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  a result pair is present this cycle (no backpressure to FFT)
- in_first  in  1  qualifies pair k = 0 of a frame; valid only with in_valid
- inReal0, inImag0  in  BW each  sample X[bitrev(2k)]
- inReal1, inImag1  in  BW each  sample X[bitrev(2k)+N/2]
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts sample when out_valid & out_ready
- outReal, outImag  out  BW each  sample X[out_idx]
- out_idx  out  LOG2N  natural-order bin index of current sample
- out_last  out  1  high with out_idx = N-1
- overflow  out  1  sticky: a frame was dropped because both buffers were busy
- sync_err  out  1  sticky: in_first arrived mid-frame, partial frame discarded

## Operation
- Storage: two frames (F0, F1), each split in low half L (bins 0..N/2-1) and high half H (bins N/2..N-1), each half N/2 × 2BW.
- Pair k write: L[bitrev_LOG2N(2k)[LOG2N-2:0]] <= {inReal0,inImag0}; H[same addr] <= {inReal1,inImag1}. Both halves written in the same cycle, no conflicts.
- Read of bin n: half = n[LOG2N-1], addr = n[LOG2N-2:0].
- Frame status per buffer: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
- Write FSM W_IDLE / W_FILL:
  - W_IDLE: in_valid & in_first & some buffer EMPTY -> write pair 0 to the EMPTY buffer (F0 preferred if both), pair counter = 1, W_FILL. No EMPTY buffer -> set overflow, ignore pairs until next in_first.
  - W_IDLE: in_valid without in_first -> ignored.
  - W_FILL: each in_valid writes pair at counter, counter++; after pair N/2-1 buffer -> FULL, W_IDLE.
  - W_FILL: in_valid & in_first -> set sync_err, discard partial frame, restart frame at pair 0 in the same buffer.
- Read FSM R_IDLE / R_STREAM:
  - R_IDLE: any buffer FULL -> mark READING (oldest first), n = 0, R_STREAM.
  - R_STREAM: emit bins 0..N-1 in order; n advances only on out_valid & out_ready. After handshake on n = N-1, buffer -> EMPTY, R_IDLE (or directly next FULL buffer with no gap).
- Same-cycle READING->EMPTY release and write-side claim: claim sees the buffer as EMPTY next cycle only (no same-cycle bypass).
- Sticky flags cleared only by rst.

## Timing
- Reset: out_valid=0, out_last=0, out_idx=0, outReal=outImag=0, overflow=0, sync_err=0, both buffers EMPTY, FSMs idle.
- Write: pair k visible to reader the cycle after its write.
- Latency: last pair written cycle t -> FULL at t+1 -> first out_valid at t+3 (1 cycle arbitration, 1 cycle registered RAM read).
- Throughput: 1 sample/cycle while out_ready=1; no bubbles inside a frame, none between back-to-back FULL frames.
- Stall: while out_valid & !out_ready, outReal/outImag/out_idx/out_last held stable; RAM read address not advanced (prefetch register or skid stage required).
- Mid-frame rst: all in-flight data dropped, outputs to reset values the next cycle.

## Structure
- Shared package fft_pkg: LOG2N/N constants, bitrev function, buffer-status encoding.
- Sub-module: existing simple_dualport_RAM, one instance per half (L, H), depth N with frame bit as address MSB; read-enable gated by stall.
- Expected size ~200-300 lines.

## Test plan
- Single frame, X[n] = {n, -n}, pairs in DIF order, out_ready=1 -> out_idx 0..63 with outReal=n, out_last at 63, first out_valid 3 cycles after last pair.
- Two frames back-to-back, ready=1 -> 128 contiguous samples, no gap at frame boundary, overflow=0.
- Random out_ready (50%) -> data stable during stall, zero loss, order intact.
- Three frames with out_ready=0 -> third frame dropped, overflow=1; after release, frames 1 and 2 stream intact.
- in_first at pair 10 of a frame -> sync_err=1, restarted frame streams correctly, stale pairs never appear.
- rst asserted mid-stream at out_idx=20 -> out_valid=0 next cycle, flags clear, next frame streams from bin 0.
